// File: rtl/pixel_mixer.sv
//-----------------------------------------------------------------------------
// pixel_mixer
//
// Row compositor that sits behind the sprite engine and the background and
// foreground tile engines. When a row is requested and all three layers have
// it prepared, it sweeps columns 0..WIDTH-1 over a shared pixel-address bus,
// resolves layer priority and transparency per pixel, looks the winning
// colour up in Palette-RAM and writes 24-bit RGB into the HDMI line buffer.
//
// Pipeline (cycle R = first RUN cycle):
//   issue  : column k on pmxr_pixel_addr in cycle R+k
//   select : layer data for k returns in R+k+1, palette address driven then
//   write  : palette data returns in R+k+2 and is written the same cycle
//
// Optional feature macro:
//   PIXEL_MIXER_LAYER_MASK_EN - adds input layer_mask[2:0]
//                               (bit0 bg, bit1 fg, bit2 sprite); a set bit
//                               forces that layer transparent for the row.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : compose the next row (only looked at in IDLE)
//   spr/bgr/fgr_done  : layer engines have the row prepared
//   pmxr_pixel_addr   : column broadcast to the layer engines
//   spr_pixel_data    : {5b palette, 4b colour}, spr_pixel_prio 2b priority
//   bgr/fgr_pixel_data: {4b palette, 4b colour}
//   backdrop          : RGB used when every layer is transparent
//   palram_addr       : Palette-RAM read address, palram_rddata 1 cycle later
//   lbuf_addr/wrdata/wren : line-buffer write port
//   busy, done        : row in progress / row finished (done high in IDLE)
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module pixel_mixer #(
  parameter int WIDTH = 320
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        spr_done,
  input  logic        bgr_done,
  input  logic        fgr_done,
  output logic [8:0]  pmxr_pixel_addr,
  input  logic [8:0]  spr_pixel_data,
  input  logic [1:0]  spr_pixel_prio,
  input  logic [7:0]  bgr_pixel_data,
  input  logic [7:0]  fgr_pixel_data,
  input  logic [23:0] backdrop,
`ifdef PIXEL_MIXER_LAYER_MASK_EN
  input  logic [2:0]  layer_mask,
`endif
  output logic [9:0]  palram_addr,
  input  logic [23:0] palram_rddata,
  output logic [8:0]  lbuf_addr,
  output logic [23:0] lbuf_wrdata,
  output logic        lbuf_wren,
  output logic        busy,
  output logic        done
);

  localparam logic [8:0] LAST_COL = 9'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t     state;
  logic [8:0] col;
  logic       drain_cnt;
  logic       layers_ready;

  // Stage-1 (select) registers: column whose layer data is arriving now.
  logic       s1_valid;
  logic [8:0] s1_col;

  // Stage-2 (write) registers: column whose palette data is arriving now.
  logic       s2_valid;
  logic [8:0] s2_col;
  logic       s2_backdrop;

  // Stage-1 combinational results.
  logic       bg_vis;
  logic       fg_vis;
  logic       spr_vis;
  logic [9:0] sel_addr;
  logic       sel_backdrop;
  logic [2:0] mask_q;

  assign layers_ready = spr_done & bgr_done & fgr_done;

  // Row control. The column counter doubles as the pixel-address output so
  // the address bus is a plain register. The counter is held at zero while
  // waiting so the first RUN cycle issues column 0 without a special case.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      col       <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          col <= '0;
          if (layers_ready) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (col == LAST_COL) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            col <= col + 9'd1;
          end
        end
        S_DRAIN: begin
          // Two cycles: enough for the last column to pass select and write.
          if (drain_cnt) begin
            state <= S_IDLE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pmxr_pixel_addr = col;
  assign busy            = (state != S_IDLE);
  assign done            = (state == S_IDLE);

`ifdef PIXEL_MIXER_LAYER_MASK_EN
  // The mask is captured as the row starts so a change mid-row cannot tear
  // the row; the last columns are still selected during DRAIN with this copy.
  logic [2:0] mask_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_r <= '0;
    end else if (state == S_WAIT && layers_ready) begin
      mask_r <= layer_mask;
    end
  end

  assign mask_q = mask_r;
`else
  assign mask_q = 3'b000;
`endif

  // Pipeline valid/column tracking. Layer data comes back exactly one cycle
  // after the column is issued, and palette data one cycle after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_col      <= '0;
      s2_valid    <= 1'b0;
      s2_col      <= '0;
      s2_backdrop <= 1'b0;
    end else begin
      s1_valid    <= (state == S_RUN);
      s1_col      <= col;
      s2_valid    <= s1_valid;
      s2_col      <= s1_col;
      s2_backdrop <= sel_backdrop;
    end
  end

  // Layer select. A colour nibble of zero is transparent; priority 0 removes
  // the sprite altogether. The sprite is slotted into the fg/bg order at the
  // position its priority asks for, which gives the three orderings with a
  // single chain of tests.
  always_comb begin
    bg_vis       = (bgr_pixel_data[3:0] != 4'd0) && !mask_q[0];
    fg_vis       = (fgr_pixel_data[3:0] != 4'd0) && !mask_q[1];
    spr_vis      = (spr_pixel_data[3:0] != 4'd0) && (spr_pixel_prio != 2'd0)
                   && !mask_q[2];
    sel_addr     = '0;
    sel_backdrop = 1'b0;
    if (spr_vis && spr_pixel_prio == 2'd3) begin
      sel_addr = {1'b1, spr_pixel_data};
    end else if (fg_vis) begin
      sel_addr = {2'b01, fgr_pixel_data};
    end else if (spr_vis && spr_pixel_prio == 2'd2) begin
      sel_addr = {1'b1, spr_pixel_data};
    end else if (bg_vis) begin
      sel_addr = {2'b00, bgr_pixel_data};
    end else if (spr_vis) begin
      sel_addr = {1'b1, spr_pixel_data};
    end else begin
      sel_backdrop = 1'b1;
    end
  end

  // The palette address is only meaningful while a selected column is in
  // stage 1; it is parked at zero otherwise so the bus is quiet between rows.
  assign palram_addr = s1_valid ? sel_addr : 10'd0;

  // Write stage. The write enable is cut by reset in the same cycle so an
  // aborted row never gets one more pixel written after reset is seen.
  assign lbuf_wren   = s2_valid && !rst;
  assign lbuf_addr   = s2_col;
  assign lbuf_wrdata = !s2_valid   ? 24'd0 :
                       s2_backdrop ? backdrop : palram_rddata;

endmodule

// File: tb/tb_pixel_mixer.sv
`timescale 1ns/1ps

module tb_pixel_mixer;

  localparam int WIDTH = 320;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        spr_done = 1'b1;
  logic        bgr_done = 1'b1;
  logic        fgr_done = 1'b1;
  logic [8:0]  pmxr_pixel_addr;
  logic [8:0]  spr_pixel_data = '0;
  logic [1:0]  spr_pixel_prio = '0;
  logic [7:0]  bgr_pixel_data = '0;
  logic [7:0]  fgr_pixel_data = '0;
  logic [23:0] backdrop = '0;
  logic [9:0]  palram_addr;
  logic [23:0] palram_rddata = '0;
  logic [8:0]  lbuf_addr;
  logic [23:0] lbuf_wrdata;
  logic        lbuf_wren;
  logic        busy;
  logic        done;
`ifdef PIXEL_MIXER_LAYER_MASK_EN
  logic [2:0]  layer_mask = 3'b000;
`endif

  int checks = 0;
  int errors = 0;

  // Layer engine and palette models configuration.
  logic        layer_mode = 1'b0;
  logic        pal_mode = 1'b0;
  logic [8:0]  spr_c = '0;
  logic [7:0]  bg_c = '0;
  logic [7:0]  fg_c = '0;

  // Line-buffer log.
  logic [23:0] mem [WIDTH];
  logic [9:0]  pa_log [WIDTH];
  int          wr_count = 0;
  int          order_err = 0;
  int          bursts = 0;
  logic [8:0]  next_addr = '0;
  logic        prev_wren = 1'b0;
  logic [9:0]  prev_pal = '0;

  typedef struct {
    logic [7:0] bg;
    logic [7:0] fg;
    logic [8:0] spr;
    logic [1:0] prio;
    logic [9:0] addr;
    logic       bd;
  } prio_vec_t;

  prio_vec_t pv [9];

  pixel_mixer #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .spr_done        (spr_done),
    .bgr_done        (bgr_done),
    .fgr_done        (fgr_done),
    .pmxr_pixel_addr (pmxr_pixel_addr),
    .spr_pixel_data  (spr_pixel_data),
    .spr_pixel_prio  (spr_pixel_prio),
    .bgr_pixel_data  (bgr_pixel_data),
    .fgr_pixel_data  (fgr_pixel_data),
    .backdrop        (backdrop),
`ifdef PIXEL_MIXER_LAYER_MASK_EN
    .layer_mask      (layer_mask),
`endif
    .palram_addr     (palram_addr),
    .palram_rddata   (palram_rddata),
    .lbuf_addr       (lbuf_addr),
    .lbuf_wrdata     (lbuf_wrdata),
    .lbuf_wren       (lbuf_wren),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pal_fn(input logic [9:0] a);
    return {4'hA, a, ~a};
  endfunction

  // Layer engines: data for the column seen at an edge appears one cycle later.
  logic [8:0] ca;
  always @(posedge clk) begin
    ca = pmxr_pixel_addr;
    #1;
    if (layer_mode) begin
      bgr_pixel_data = ca[7:0];
      fgr_pixel_data = 8'h00;
      spr_pixel_data = 9'h000;
    end else begin
      bgr_pixel_data = bg_c;
      fgr_pixel_data = fg_c;
      spr_pixel_data = spr_c;
    end
  end

  // Palette RAM with registered read data.
  logic [9:0] pa_s;
  always @(posedge clk) begin
    pa_s = palram_addr;
    #1;
    palram_rddata = pal_mode ? pal_fn(pa_s) : 24'hAABBCC;
  end

  // Line-buffer monitor; the palette address of a column is the one seen the
  // cycle before its write.
  always @(negedge clk) begin
    if (lbuf_wren === 1'b1) begin
      if (!prev_wren) bursts++;
      if (int'(lbuf_addr) < WIDTH) begin
        mem[int'(lbuf_addr)]    = lbuf_wrdata;
        pa_log[int'(lbuf_addr)] = prev_pal;
      end
      if (lbuf_addr !== next_addr) order_err++;
      next_addr = (next_addr == 9'(WIDTH - 1)) ? 9'd0 : next_addr + 9'd1;
      wr_count++;
    end
    prev_wren = (lbuf_wren === 1'b1);
    prev_pal  = palram_addr;
  end

  task automatic clear_log();
    for (int i = 0; i < WIDTH; i++) begin
      mem[i]    = 24'hFFFFFF;
      pa_log[i] = 10'h3FF;
    end
    wr_count  = 0;
    order_err = 0;
    bursts    = 0;
    next_addr = '0;
  endtask

  // Pulse start for one cycle and count edges until done comes back.
  task automatic run_row(output int cycles);
    clear_log();
    @(posedge clk); #1;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 1;
    while (!done && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (pmxr_pixel_addr !== 9'd0) begin errors++; $display("[TB] FAIL reset_pixel_addr got %h want 0", pmxr_pixel_addr); end
    checks++; if (palram_addr !== 10'd0) begin errors++; $display("[TB] FAIL reset_palram_addr got %h want 0", palram_addr); end
    checks++; if (lbuf_addr !== 9'd0) begin errors++; $display("[TB] FAIL reset_lbuf_addr got %h want 0", lbuf_addr); end
    checks++; if (lbuf_wrdata !== 24'd0) begin errors++; $display("[TB] FAIL reset_lbuf_wrdata got %h want 0", lbuf_wrdata); end
    checks++; if (lbuf_wren !== 1'b0) begin errors++; $display("[TB] FAIL reset_lbuf_wren got %b want 0", lbuf_wren); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL reset_done got %b want 1", done); end
  endtask

  task automatic test_backdrop();
    int cyc;
    int bad;
    layer_mode = 1'b0; pal_mode = 1'b1;
    bg_c = 8'h50; fg_c = 8'hA0; spr_c = 9'h1F0; spr_pixel_prio = 2'd3;
    backdrop = 24'h123456;
    run_row(cyc);
    bad = 0;
    for (int i = 0; i < WIDTH; i++) if (mem[i] !== 24'h123456) bad++;
    checks++; if (cyc != 324) begin errors++; $display("[TB] FAIL backdrop_latency got %0d want 324", cyc); end
    checks++; if (wr_count != WIDTH) begin errors++; $display("[TB] FAIL backdrop_wr_count got %0d want %0d", wr_count, WIDTH); end
    checks++; if (bursts != 1) begin errors++; $display("[TB] FAIL backdrop_bursts got %0d want 1", bursts); end
    checks++; if (order_err != 0) begin errors++; $display("[TB] FAIL backdrop_order got %0d want 0", order_err); end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL backdrop_data bad %0d want 0 (col0 got %h want 123456)", bad, mem[0]); end
  endtask

  task automatic test_bg_only();
    int cyc;
    int bad_pa;
    int bad_d;
    layer_mode = 1'b0; pal_mode = 1'b0;
    bg_c = 8'h35; fg_c = 8'h00; spr_c = 9'h1F0; spr_pixel_prio = 2'd3;
    backdrop = 24'h111111;
    run_row(cyc);
    bad_pa = 0; bad_d = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pa_log[i] !== 10'h035) bad_pa++;
      if (mem[i] !== 24'hAABBCC) bad_d++;
    end
    checks++; if (bad_pa != 0) begin errors++; $display("[TB] FAIL bg_only_palram_addr bad %0d (col5 got %h want 035)", bad_pa, pa_log[5]); end
    checks++; if (bad_d != 0) begin errors++; $display("[TB] FAIL bg_only_data bad %0d (col5 got %h want aabbcc)", bad_d, mem[5]); end
    checks++; if (wr_count != WIDTH) begin errors++; $display("[TB] FAIL bg_only_wr_count got %0d want %0d", wr_count, WIDTH); end
  endtask

  task automatic test_column_pattern();
    int cyc;
    int bad;
    int first_bad;
    logic [8:0]  cc;
    logic [23:0] exp_d;
    layer_mode = 1'b1; pal_mode = 1'b1; spr_pixel_prio = 2'd0;
    backdrop = 24'h0F0F0F;
    run_row(cyc);
    bad = 0; first_bad = -1;
    for (int c = 0; c < WIDTH; c++) begin
      cc = 9'(c);
      exp_d = (cc[3:0] == 4'd0) ? 24'h0F0F0F : pal_fn({2'b00, cc[7:0]});
      if (mem[c] !== exp_d) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL column_pattern bad %0d first col %0d", bad, first_bad); end
    checks++; if (order_err != 0) begin errors++; $display("[TB] FAIL column_order got %0d want 0", order_err); end
    layer_mode = 1'b0;
  endtask

  task automatic test_priority();
    int cyc;
    int bad;
    logic [23:0] exp_d;
    pv[0] = '{8'h21, 8'h72, 9'h1A3, 2'd3, 10'h3A3, 1'b0};
    pv[1] = '{8'h21, 8'h72, 9'h1A3, 2'd2, 10'h172, 1'b0};
    pv[2] = '{8'h21, 8'h72, 9'h1A3, 2'd1, 10'h172, 1'b0};
    pv[3] = '{8'h21, 8'h72, 9'h1A3, 2'd0, 10'h172, 1'b0};
    pv[4] = '{8'h21, 8'h70, 9'h1A3, 2'd2, 10'h3A3, 1'b0};
    pv[5] = '{8'h21, 8'h70, 9'h1A3, 2'd1, 10'h021, 1'b0};
    pv[6] = '{8'h20, 8'h70, 9'h1A3, 2'd1, 10'h3A3, 1'b0};
    pv[7] = '{8'h20, 8'h70, 9'h1A3, 2'd0, 10'h000, 1'b1};
    pv[8] = '{8'h21, 8'h72, 9'h1A0, 2'd3, 10'h172, 1'b0};
    layer_mode = 1'b0; pal_mode = 1'b1; backdrop = 24'h654321;
    for (int v = 0; v < 9; v++) begin
      bg_c = pv[v].bg; fg_c = pv[v].fg; spr_c = pv[v].spr;
      spr_pixel_prio = pv[v].prio;
      run_row(cyc);
      exp_d = pv[v].bd ? 24'h654321 : pal_fn(pv[v].addr);
      bad = 0;
      for (int i = 0; i < WIDTH; i++) begin
        if (mem[i] !== exp_d) bad++;
        if (!pv[v].bd && pa_log[i] !== pv[v].addr) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("[TB] FAIL prio_vec%0d col7 addr got %h want %h data got %h want %h (bad %0d)",
                 v, pa_log[7], pv[v].addr, mem[7], exp_d, bad);
      end
    end
  endtask

  task automatic test_layer_mask();
    int cyc;
    logic [9:0] exp_a;
    layer_mode = 1'b0; pal_mode = 1'b1;
    bg_c = 8'h21; fg_c = 8'h72; spr_c = 9'h1A3; spr_pixel_prio = 2'd3;
`ifdef PIXEL_MIXER_LAYER_MASK_EN
    layer_mask = 3'b100;
    exp_a = 10'h172;
`else
    exp_a = 10'h3A3;
`endif
    run_row(cyc);
    checks++; if (pa_log[7] !== exp_a) begin errors++; $display("[TB] FAIL layer_mask_addr got %h want %h", pa_log[7], exp_a); end
    checks++; if (mem[200] !== pal_fn(exp_a)) begin errors++; $display("[TB] FAIL layer_mask_data got %h want %h", mem[200], pal_fn(exp_a)); end
`ifdef PIXEL_MIXER_LAYER_MASK_EN
    layer_mask = 3'b000;
`endif
  endtask

  task automatic test_wait_hold();
    int n;
    int changes;
    logic [8:0] a0;
    layer_mode = 1'b0; pal_mode = 1'b0;
    bg_c = 8'h35; fg_c = 8'h00; spr_c = 9'h000; spr_pixel_prio = 2'd0;
    clear_log();
    fgr_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    a0 = pmxr_pixel_addr;
    changes = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (pmxr_pixel_addr !== a0) changes++;
    end
    checks++; if (changes != 0) begin errors++; $display("[TB] FAIL wait_addr_activity got %0d changes want 0", changes); end
    checks++; if (wr_count != 0) begin errors++; $display("[TB] FAIL wait_writes got %0d want 0", wr_count); end
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL wait_status got busy %b done %b want busy 1 done 0", busy, done); end
    fgr_done = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (pmxr_pixel_addr !== 9'd1) begin errors++; $display("[TB] FAIL wait_run_start got addr %0d want 1", pmxr_pixel_addr); end
    // Start is still held here; drop it, drop a layer done, re-pulse start mid-row.
    start    = 1'b0;
    fgr_done = 1'b0;
    n = 0;
    while (!done && n < 1000) begin
      @(posedge clk); #1;
      n++;
      start = (busy && pmxr_pixel_addr == 9'd150);
    end
    start = 1'b0;
    checks++; if (n != 321) begin errors++; $display("[TB] FAIL wait_done_cycle got %0d want 321", n); end
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL second_start_ignored got busy %b done %b want busy 0 done 1", busy, done); end
    checks++; if (wr_count != WIDTH || bursts != 1) begin errors++; $display("[TB] FAIL wait_row_writes got %0d bursts %0d want %0d bursts 1", wr_count, bursts, WIDTH); end
    fgr_done = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    layer_mode = 1'b0; pal_mode = 1'b0;
    bg_c = 8'h35; fg_c = 8'h00; spr_c = 9'h000; spr_pixel_prio = 2'd0;
    clear_log();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(busy && pmxr_pixel_addr == 9'd100) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n >= 1000) begin errors++; $display("[TB] FAIL reset_mid_reach_col100 got timeout want col 100"); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b1 || lbuf_wren !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_status got busy %b done %b wren %b want 0 1 0", busy, done, lbuf_wren); end
    checks++; if (wr_count != 98) begin errors++; $display("[TB] FAIL reset_mid_writes got %0d want 98", wr_count); end
    repeat (20) begin @(posedge clk); #1; end
    checks++; if (wr_count != 98 || busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_after got writes %0d busy %b want 98 0", wr_count, busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    layer_mode = 1'b0; pal_mode = 1'b0;
    bg_c = 8'h35; fg_c = 8'h00; spr_c = 9'h000; spr_pixel_prio = 2'd0;
    clear_log();
    @(posedge clk); #1;
    start = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done && n < 2000);
    checks++; if (n != 324) begin errors++; $display("[TB] FAIL b2b_first_done got %0d want 324", n); end
    do begin @(posedge clk); #1; n++; end while (done && n < 2000);
    start = 1'b0;
    while (!done && n < 2000) begin @(posedge clk); #1; n++; end
    checks++; if (n != 648) begin errors++; $display("[TB] FAIL b2b_second_done got %0d want 648", n); end
    checks++; if (wr_count != 2 * WIDTH || bursts != 2 || order_err != 0) begin errors++; $display("[TB] FAIL b2b_writes got %0d bursts %0d order %0d want %0d 2 0", wr_count, bursts, order_err, 2 * WIDTH); end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_backdrop();
    test_bg_only();
    test_column_pattern();
    test_priority();
    test_layer_mask();
    test_wait_hold();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_mixer.md
# pixel_mixer

Row compositor downstream of the sprite engine and the two tile-layer engines (background, foreground). Once all layers report the next row prepared, it sweeps pixel columns 0–319 over a shared pixel-address bus. Per pixel it resolves layer priority and transparency, looks up the winning colour in Palette-RAM, and writes 24-bit RGB into the HDMI line buffer. The datapath is a three-stage pipeline: address issue, layer select, palette write.

## Interface
- `WIDTH`, 320: pixels per row; the column counter runs 0..WIDTH-1.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request to compose the next row. Level-sensed in IDLE only.
- `spr_done`, `bgr_done`, `fgr_done` in 1 each: layer engines have finished preparing the row.
- `pmxr_pixel_addr` out 9: column broadcast to all three layer engines. Their data returns exactly 1 cycle later.
- `spr_pixel_data` in 9: {5b palette, 4b colour}.
- `spr_pixel_prio` in 2: sprite priority.
- `bgr_pixel_data`, `fgr_pixel_data` in 8 each: {4b palette, 4b colour}.
- `backdrop` in 24: RGB used when every layer is transparent.
- `palram_addr` out 10: Palette-RAM read address. Registered read data returns 1 cycle later.
- `palram_rddata` in 24: RGB.
- `lbuf_addr` out 9, `lbuf_wrdata` out 24, `lbuf_wren` out 1: line-buffer write port.
- `busy` out 1: state is not IDLE.
- `done` out 1: row written; high in IDLE.

## Operation
- **IDLE**
  - `done`=1, `busy`=0.
  - `start`=1 moves to WAIT.
- **WAIT**
  - Moves to RUN when `spr_done & bgr_done & fgr_done` are all high. This may be the very next cycle.
  - The column counter is cleared to 0.
- **RUN**
  - Each cycle: `pmxr_pixel_addr` = col, then col increments.
  - After issuing col = WIDTH-1, moves to DRAIN.
- **DRAIN**
  - Lasts 2 cycles and flushes stages 1–2, then returns to IDLE.
- **Stage 1 (select)**, on the returned data:
  - A layer is transparent when its colour nibble is 0.
  - Sprite order by `spr_pixel_prio`:
    - 3: sprite > fg > bg
    - 2: fg > sprite > bg
    - 1: fg > bg > sprite
    - 0: sprite ignored
  - Palette address of the winner:
    - bg: {2'b00, pal, colour}
    - fg: {2'b01, pal, colour}
    - sprite: {1'b1, pal, colour}
  - No winner: a backdrop flag is set, and `palram_addr` is don't-care.
  - The stage-1 column and flag are carried forward with the data.
- **Stage 2 (write)**
  - `lbuf_wren`=1, `lbuf_addr` = stage-2 column.
  - `lbuf_wrdata` = `backdrop` if the flag is set, otherwise `palram_rddata`.
- Boundary conditions:
  - `start` outside IDLE is ignored. There is no queuing.
  - Layer `*_done` deasserting during RUN is ignored.
  - `rst` at any point returns to IDLE within one cycle and aborts the row. The write already in progress in that cycle is suppressed, so a partial row may remain in the line buffer.

## Timing
- Reset values:
  - `pmxr_pixel_addr`=0, `palram_addr`=0, `lbuf_addr`=0, `lbuf_wrdata`=0.
  - `lbuf_wren`=0, `busy`=0, `done`=1.
- Cycle numbering from WAIT→RUN at cycle R:
  - col k is issued in cycle R+k.
  - Its palette address is presented in cycle R+k+1.
  - Its line-buffer write occurs in cycle R+k+2.
- `lbuf_wren` is high for exactly WIDTH consecutive cycles per row.
- `done` rises in cycle R+WIDTH+2, the cycle after the last write.
- Best case, `start` to `done`: WIDTH+4 cycles. That is 324 at the default WIDTH when the layers are already done.

## Configuration
- `PIXEL_MIXER_LAYER_MASK_EN`
  - Defined: adds input `layer_mask` [2:0] (bit0 bg, bit1 fg, bit2 sprite). A set bit forces that layer transparent in stage 1. The mask is sampled on entry to RUN and held for the whole row.
  - Undefined: the port does not exist and all layers take part.

## Test plan
- Reset mid-RUN at col 100 → next cycle: `busy`=0, `done`=1, `lbuf_wren`=0; no further writes.
- All layers colour 0, `backdrop`=24'h123456 → 320 writes of 24'h123456 at addresses 0..319, with no dependence on palram.
- bg=8'h35, fg=8'h00, sprite colour 0 → `palram_addr`=10'h035. `palram_rddata`=24'hAABBCC is written at the matching column.
- bg=8'h21, fg=8'h72, sprite=9'h1A3:
  - prio 3 → 10'h3A3
  - prio 2 → 10'h172
  - prio 0 → 10'h172
- `start` held with `fgr_done`=0 for 50 cycles → no `pmxr_pixel_addr` activity; RUN begins 1 cycle after `fgr_done` rises. A second `start` during RUN is ignored.
- With `PIXEL_MIXER_LAYER_MASK_EN`, mask=3'b100 and sprite prio 3 → the fg palette address is used. Without the macro, the sprite address is used.
